// File: rtl/serial_cmd_decoder.sv
// Consumes receiver bytes over a level RDY/RD_ACK handshake and decodes HDR/index/value/XOR frames into a register file.
// Optional SERIAL_CMD_ERR_CNT_EN adds a saturating ERR_CNT output, cleared by a checksummed frame with index 8'hFF.
module serial_cmd_decoder #(
  parameter int          AW      = 3,
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_RDY,
  output logic                 RD_ACK,
  output logic                 WE,
  output logic [AW-1:0]        WADDR,
  output logic [7:0]           WDATA,
  output logic [8*(2**AW)-1:0] REGS,
  output logic                 ERR
`ifdef SERIAL_CMD_ERR_CNT_EN
  ,
  output logic [7:0]           ERR_CNT
`endif
);

  localparam int NREG = 2**AW;

  typedef enum logic {H_IDLE, H_ACK} hs_t;
  typedef enum logic [1:0] {P_HDR, P_IDX, P_VAL, P_CHK} ps_t;

  hs_t                  r_hst;
  ps_t                  r_pst;
  logic                 r_rd_ack;
  logic                 r_we;
  logic                 r_err;
  logic [AW-1:0]        r_waddr;
  logic [7:0]           r_wdata;
  logic [NREG-1:0][7:0] r_regs;
  logic [7:0]           r_idx;
  logic [7:0]           r_val;
  logic [7:0]           r_chk;
  logic [15:0]          r_tmo;

  logic w_cap;
  logic w_chk_ok;
  logic w_in_rng;
  logic w_end;
  logic w_clr;
  logic w_wr;
  logic w_tmo;
  logic w_err;

  // A byte is taken only from H_IDLE, so RD_ACK must drop before the next capture.
  assign w_cap    = (r_hst == H_IDLE) && RX_RDY;
  assign w_chk_ok = (RX_DATA == r_chk);
  assign w_in_rng = ((r_idx >> AW) == 8'd0);
  assign w_end    = w_cap && (r_pst == P_CHK);
  assign w_wr     = w_end && w_chk_ok && w_in_rng && !w_clr;
  // Capture wins over a coincident timeout.
  assign w_tmo    = !w_cap && (r_pst != P_HDR) && ((r_tmo + 16'd1) == TIMEOUT);
  assign w_err    = (w_end && !w_wr && !w_clr) || w_tmo;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hst    <= H_IDLE;
      r_rd_ack <= 1'b0;
    end else begin
      case (r_hst)
        H_IDLE: begin
          if (RX_RDY) begin
            r_rd_ack <= 1'b1;
            r_hst    <= H_ACK;
          end
        end
        H_ACK: begin
          if (!RX_RDY) begin
            r_rd_ack <= 1'b0;
            r_hst    <= H_IDLE;
          end
        end
        default: begin
          r_rd_ack <= 1'b0;
          r_hst    <= H_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pst   <= P_HDR;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 8'd0;
      r_regs  <= '0;
      r_idx   <= 8'd0;
      r_val   <= 8'd0;
      r_chk   <= 8'd0;
      r_tmo   <= 16'd0;
    end else begin
      r_we  <= w_wr;
      r_err <= w_err;
      if (w_cap) begin
        r_tmo <= 16'd0;
        case (r_pst)
          P_HDR: begin
            if (RX_DATA == HDR) begin
              r_chk <= HDR;
              r_pst <= P_IDX;
            end
          end
          P_IDX: begin
            r_idx <= RX_DATA;
            r_chk <= r_chk ^ RX_DATA;
            r_pst <= P_VAL;
          end
          P_VAL: begin
            r_val <= RX_DATA;
            r_chk <= r_chk ^ RX_DATA;
            r_pst <= P_CHK;
          end
          P_CHK: begin
            r_pst <= P_HDR;
            if (w_wr) begin
              r_regs[r_idx[AW-1:0]] <= r_val;
              r_waddr               <= r_idx[AW-1:0];
              r_wdata               <= r_val;
            end
          end
          default: r_pst <= P_HDR;
        endcase
      end else if (r_pst == P_HDR) begin
        r_tmo <= 16'd0;
      end else if (w_tmo) begin
        r_pst <= P_HDR;
        r_tmo <= 16'd0;
      end else begin
        r_tmo <= r_tmo + 16'd1;
      end
    end
  end

`ifdef SERIAL_CMD_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  assign w_clr = w_end && w_chk_ok && (r_idx == 8'hFF);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err_cnt <= 8'd0;
    end else if (w_clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign ERR_CNT = r_err_cnt;
`else
  assign w_clr = 1'b0;
`endif

  assign RD_ACK = r_rd_ack;
  assign WE     = r_we;
  assign ERR    = r_err;
  assign WADDR  = r_waddr;
  assign WDATA  = r_wdata;
  assign REGS   = r_regs;

endmodule
